ps2_scan_rx: RTL and testbench

//  Oversampled PS/2 keyboard receiver: synchronises and deglitches KBCLK/KBDAT in the CLOCK domain,

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_scan_rx.sv | 255 +++++++++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 scan-code receiver:
//                frame state encoding, prefix bytes, error flag indices and
//                the layout of the tagged scan-code word.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Frame deserialiser states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Prefix bytes folded into the tag bits of the following code
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Bit positions inside err_flags
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVF     = 3;
    localparam int ERR_W       = 4;

    // Tagged code word layout
    localparam int CODE_W       = 10;
    localparam int CODE_EXT_BIT = 9;
    localparam int CODE_BRK_BIT = 8;

    // Build a tagged code word from the pending prefix flags and a scan byte
    function automatic logic [CODE_W-1:0] make_code(input logic       ext,
                                                    input logic       brk,
                                                    input logic [7:0] scan);
        logic [CODE_W-1:0] code;
        code               = {2'b00, scan};
        code[CODE_EXT_BIT] = ext;
        code[CODE_BRK_BIT] = brk;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_filter
//  Description : Two-flop synchroniser followed by a run-length deglitcher.
//                The filtered level only changes after FILTER_LEN
//                consecutive synchronised samples disagree with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLOCK,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_run_cnt;

    // Bring the asynchronous pin into the CLOCK domain; idle bus level is 1
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the run
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b1;
            r_run_cnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt == C_CNT_LAST) begin
            r_level   <= r_sync2;
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign line_out = r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_rx
//  Description : Oversampled PS/2 keyboard receiver. Filters KBCLK/KBDAT,
//                deframes 11-bit frames, checks parity and stop bit, folds
//                E0/F0 prefixes into tag bits and queues the tagged codes
//                in a valid/ready FIFO. Sticky error flags report parity,
//                framing, timeout and overflow events.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic [9:0] code_data,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [3:0] err_flags,
    input  logic       err_clr,
    output logic       busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_FIFO_FULL = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_clk_f;
    logic w_dat_f;
    logic r_clk_prev;
    logic w_strobe;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .CLOCK    (CLOCK),
        .rst_n    (rst_n),
        .line_in  (PS2_KBCLK),
        .line_out (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .CLOCK    (CLOCK),
        .rst_n    (rst_n),
        .line_in  (PS2_KBDAT),
        .line_out (w_dat_f)
    );

    // Remember the previous filtered clock level for fall detection
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) r_clk_prev <= 1'b1;
        else        r_clk_prev <= w_clk_f;
    end

    assign w_strobe = r_clk_prev & ~w_clk_f;

    // ------------------------------------------------------------------
    // Frame deserialiser
    // ------------------------------------------------------------------
    ps2_state_t       r_state,  w_state_nxt;
    logic [7:0]       r_shift,  w_shift_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic             r_par_bit, w_par_bit_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_byte_ok;
    logic             w_err_par;
    logic             w_err_frame;
    logic             w_err_tmo;

    // Deserialiser state register
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_par_bit <= w_par_bit_nxt;
        end
    end

    // Next-state logic; every transition is gated by the clock strobe
    // except the inter-bit timeout, which can abort any non-idle state
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_par_bit_nxt = r_par_bit;
        w_byte_ok     = 1'b0;
        w_err_par     = 1'b0;
        w_err_frame   = 1'b0;
        w_err_tmo     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_strobe && !w_dat_f) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (w_strobe) begin
                    w_shift_nxt   = {w_dat_f, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (w_strobe) begin
                    w_par_bit_nxt = w_dat_f;
                    w_state_nxt   = STOP;
                end
            end
            STOP: begin
                if (w_strobe) begin
                    w_state_nxt = IDLE;
                    // Odd parity: data ones plus parity bit must be odd
                    w_err_par   = ~(^r_shift ^ r_par_bit);
                    w_err_frame = ~w_dat_f;
                    w_byte_ok   = ~w_err_par & w_dat_f;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if ((r_state != IDLE) && !w_strobe && (r_tmo_cnt == C_TMO_LAST)) begin
            w_state_nxt = IDLE;
            w_err_tmo   = 1'b1;
        end
    end

    // Inter-bit watchdog: restarts on each strobe, idle holds it at zero
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n)                          r_tmo_cnt <= '0;
        else if (r_state == IDLE || w_strobe) r_tmo_cnt <= '0;
        else                                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign busy = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Prefix assembler
    // ------------------------------------------------------------------
    logic              r_ext;
    logic              r_brk;
    logic              r_push;
    logic [CODE_W-1:0] r_push_code;

    // Fold E0/F0 into tag flags; a parity or framing error drops them so
    // the next code is untagged, whereas a timeout leaves them pending
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_push      <= 1'b0;
            r_push_code <= '0;
        end else begin
            r_push <= 1'b0;
            if (w_byte_ok) begin
                if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_push_code <= make_code(r_ext, r_brk, r_shift);
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end else if (w_err_par || w_err_frame) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Code FIFO
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_ovf;

    assign code_valid = (r_count != '0);
    assign w_full     = (r_count == C_FIFO_FULL);
    assign w_pop      = code_valid & code_ready;
    // A pop in the same cycle frees the slot, so full+push+pop still writes
    assign w_wr_en    = r_push & (~w_full | w_pop);
    assign w_ovf      = r_push & w_full & ~w_pop;
    assign code_data  = code_valid ? r_mem[r_rd_ptr] : '0;

    // Storage array; contents are only observable through the valid-gated head
    always_ff @(posedge CLOCK) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_push_code;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] w_new_err;
    logic [ERR_W-1:0] r_err;

    // Gather this cycle's error events into flag positions
    always_comb begin
        w_new_err              = '0;
        w_new_err[ERR_PARITY]  = w_err_par;
        w_new_err[ERR_FRAME]   = w_err_frame;
        w_new_err[ERR_TIMEOUT] = w_err_tmo;
        w_new_err[ERR_OVF]     = w_ovf;
    end

    // Clear has lower priority than a coincident new error
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) r_err <= '0;
        else        r_err <= (r_err & {ERR_W{~err_clr}}) | w_new_err;
    end

    assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scan_rx
//  Description : Directed self-checking bench for ps2_scan_rx. Drives PS/2
//                frames bit by bit and compares queued codes and error flags
//                against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_rx;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 10;   // CLOCK cycles per PS/2 clock half-period

    logic       CLOCK = 1'b0;
    logic       rst_n = 1'b0;
    logic       PS2_KBCLK = 1'b1;
    logic       PS2_KBDAT = 1'b1;
    logic [9:0] code_data;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic [3:0] err_flags;
    logic       err_clr = 1'b0;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    ps2_scan_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .CLOCK      (CLOCK),
        .rst_n      (rst_n),
        .PS2_KBCLK  (PS2_KBCLK),
        .PS2_KBDAT  (PS2_KBDAT),
        .code_data  (code_data),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err_flags  (err_flags),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send the first nbits of a frame; par_flip inverts the odd-parity bit,
    // chk_lat checks code_valid timing around the stop-bit fall
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_b, input int nbits, input logic chk_lat);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = (~^b) ^ par_flip;
        fr[10]  = stop_b;
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK);
            PS2_KBDAT = fr[i];
            repeat (HALF) @(negedge CLOCK);
            PS2_KBCLK = 1'b0;
            if (chk_lat && i == 10) begin
                repeat (7) @(posedge CLOCK);
                #1 check_val("lat_valid_low", {31'd0, code_valid}, 32'd0);
                @(posedge CLOCK);
                #1 check_val("lat_valid_high", {31'd0, code_valid}, 32'd1);
                repeat (HALF - 8) @(negedge CLOCK);
            end else begin
                repeat (HALF) @(negedge CLOCK);
            end
            PS2_KBCLK = 1'b1;
        end
        @(negedge CLOCK);
        PS2_KBDAT = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    // Wait (bounded) for a code, compare it, then pop it
    task automatic pop_expect(input string tag, input logic [9:0] exp);
        int n = 0;
        while (!code_valid && n < 100) begin
            @(negedge CLOCK);
            n++;
        end
        check_val({tag, "_data"}, {22'd0, code_data}, {22'd0, exp});
        code_ready = 1'b1;
        @(negedge CLOCK);
        code_ready = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge CLOCK);
        err_clr = 1'b1;
        @(negedge CLOCK);
        err_clr = 1'b0;
        check_val("err_cleared", {28'd0, err_flags}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge CLOCK);
        check_val("rst_valid", {31'd0, code_valid}, 32'd0);
        check_val("rst_data",  {22'd0, code_data},  32'd0);
        check_val("rst_err",   {28'd0, err_flags},  32'd0);
        check_val("rst_busy",  {31'd0, busy},       32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge CLOCK);

        // Plain code with exact latency
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
        pop_expect("plain_1c", 10'h01C);
        check_val("plain_empty", {31'd0, code_valid}, 32'd0);

        // Prefix folding
        send_byte(8'hE0); send_byte(8'h75);
        pop_expect("ext_75", 10'h275);
        check_val("ext_single", {31'd0, code_valid}, 32'd0);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        pop_expect("extbrk_75", 10'h375);
        send_byte(8'hF0); send_byte(8'h1C);
        pop_expect("brk_1c", 10'h11C);
        check_val("prefix_empty", {31'd0, code_valid}, 32'd0);

        // Parity error drops pending prefix
        send_byte(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        repeat (10) @(negedge CLOCK);
        check_val("par_nopush", {31'd0, code_valid}, 32'd0);
        check_val("par_err",    {28'd0, err_flags},  32'd1);
        send_byte(8'h32);
        pop_expect("after_par", 10'h032);
        clear_err();

        // Framing error
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        repeat (10) @(negedge CLOCK);
        check_val("frame_err",    {28'd0, err_flags},  32'h2);
        check_val("frame_nopush", {31'd0, code_valid}, 32'd0);
        clear_err();

        // Timeout after start + 4 data bits
        send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        check_val("tmo_busy_mid", {31'd0, busy}, 32'd1);
        repeat (TIMEOUT_CYC + 50) @(negedge CLOCK);
        check_val("tmo_err",  {28'd0, err_flags}, 32'h4);
        check_val("tmo_busy", {31'd0, busy},      32'd0);
        clear_err();
        send_byte(8'h32);
        pop_expect("after_tmo", 10'h032);

        // Overflow: depth+1 codes with no consumer
        for (int i = 0; i <= FIFO_DEPTH; i++) send_byte(8'h10 + 8'(i));
        repeat (5) @(negedge CLOCK);
        check_val("ovf_err", {28'd0, err_flags}, 32'h8);
        for (int i = 0; i < FIFO_DEPTH; i++)
            pop_expect($sformatf("drain%0d", i), 10'h010 + 10'(i));
        check_val("drain_empty", {31'd0, code_valid}, 32'd0);
        clear_err();

        // Short KBCLK glitches while the data line looks like a start bit
        PS2_KBDAT = 1'b0;
        repeat (10) @(negedge CLOCK);
        PS2_KBCLK = 1'b0;
        @(negedge CLOCK);
        PS2_KBCLK = 1'b1;
        repeat (20) @(negedge CLOCK);
        check_val("glitch1_busy", {31'd0, busy}, 32'd0);
        PS2_KBCLK = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge CLOCK);
        PS2_KBCLK = 1'b1;
        repeat (20) @(negedge CLOCK);
        check_val("glitch3_busy", {31'd0, busy}, 32'd0);
        PS2_KBDAT = 1'b1;
        repeat (10) @(negedge CLOCK);

        // Reset mid-frame with a queued code and a pending prefix
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_frame(8'h75, 1'b0, 1'b1, 4, 1'b0);
        check_val("pre_rst_busy",  {31'd0, busy},       32'd1);
        check_val("pre_rst_valid", {31'd0, code_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge CLOCK);
        check_val("mid_rst_valid", {31'd0, code_valid}, 32'd0);
        check_val("mid_rst_data",  {22'd0, code_data},  32'd0);
        check_val("mid_rst_busy",  {31'd0, busy},       32'd0);
        check_val("mid_rst_err",   {28'd0, err_flags},  32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge CLOCK);
        send_byte(8'h75);
        pop_expect("after_rst", 10'h075);
        check_val("after_rst_err", {28'd0, err_flags}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
